uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage that sits directly upstream of the four-digit LED display driver.
- Recovers 8-bit bytes from the asynchronous RxD line using 16x oversampling and checks parity and framing.
- Presents each byte on Rx_DATA, which feeds the display driver's 8-bit data input, together with a one-cycle valid strobe and error flags.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency; used to build the baud divisor table.
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- baud_select, input, 3, baud rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
- Rx_EN, input, 1, receiver enable.
- RxD, input, 1, asynchronous serial line; idles high.
- Rx_DATA, output, 8, last received byte.
- Rx_VALID, output, 1, one-cycle pulse when a frame completes.
- Rx_PERROR, output, 1, parity error for the last frame.
- Rx_FERROR, output, 1, framing error (stop bit low) for the last frame.
- Rx_BUSY, output, 1, high while the FSM is outside IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0, except Rx_DATA=8'h00;
  - FSM in IDLE, counters 0, synchroniser flops set to 1.
- Input sync: RxD passes through a 2-flop synchroniser (rxd_s); all decisions use rxd_s.
- Oversample tick:
  - divisor = round(CLK_FREQ_HZ/(16*baud)); at 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
  - 14-bit down-counter emits a 1-clk tick on reaching 0, then reloads divisor-1.
  - baud_select is latched at start detection; changes mid-frame take effect on the next frame only.
- Frame format: start(0), D0..D7 LSB first, parity, stop(1).
- FSM states and transitions:
  - IDLE: Rx_BUSY=0. If Rx_EN=1 and rxd_s=0: latch divisor, clear tick and sample counters, go to START.
  - START: after 8 ticks (mid-bit), sample rxd_s. If 1, it is a false start: return to IDLE with no flags. If 0, go to DATA with sample count 0.
  - DATA: every 16 ticks, sample and shift right into a shift register (MSB-in). After the 8th bit, go to PARITY.
  - PARITY: after 16 ticks, sample the parity bit. perr = (^shift) ^ bit ^ PARITY_ODD. Go to STOP.
  - STOP: after 16 ticks, sample the stop bit. Load Rx_DATA=shift, Rx_PERROR=perr, Rx_FERROR=~bit, and pulse Rx_VALID for 1 clk in the same cycle. Return to IDLE.
- Rx_VALID fires even when error flags are set.
- Rx_DATA and the error flags hold until the next Rx_VALID.
- Return to IDLE at the stop-bit midpoint allows back-to-back frames; the next start edge is detected in the second half of the stop bit.
- Latency: Rx_VALID occurs 168 ticks after start detection (about 168*divisor clks, plus 2-3 clks for sync and detection).
- Rx_EN falling mid-frame aborts to IDLE on the next clk. No Rx_VALID is issued; outputs keep their previous values.
- rxd_s low at power-up or held low (break): one false start, or one frame with Rx_FERROR=1. The FSM then waits in IDLE until rxd_s returns high before it arms again (re-arm requires rxd_s=1 for at least 1 clk).
- Simultaneous tick and abort: abort wins.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit value is the majority of samples at ticks 7, 8 and 9 of the bit. The start-bit check uses the same vote. The decision is taken at tick 9, which adds 1 tick of latency per frame (169 ticks total).
- Undefined: single sample at tick 8; 168-tick latency.

Test Plan:
- Reset check: reset=0 pulsed mid-frame (at 115200, clk 50 MHz) → all outputs 0 asynchronously; FSM in IDLE; no Rx_VALID after release until a new full frame.
- Good frame: baud_select=111, PARITY_ODD=0, send 0xA5 with parity 0 and stop 1 → one Rx_VALID pulse; Rx_DATA=8'hA5, Rx_PERROR=0, Rx_FERROR=0; pulse within 4536..4540 clks of the start edge.
- Parity error: same setup, send 0x3C with parity 1 → Rx_VALID=1, Rx_DATA=8'h3C, Rx_PERROR=1, Rx_FERROR=0.
- Framing error: baud_select=011, send 0x00 with stop bit 0 → Rx_VALID=1, Rx_FERROR=1; no second frame until the line returns high.
- False start and back-to-back: a 100-clk low glitch at 115200 → no Rx_VALID, Rx_BUSY drops by tick 8. Then 0x55 and 0xAA sent back-to-back with a 1-stop-bit gap → two Rx_VALID pulses carrying 8'h55 then 8'hAA.
- Baud change and abort: change baud_select mid-frame → current byte is received correctly at the old rate. Deassert Rx_EN during D3 → no Rx_VALID, Rx_DATA unchanged.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled 8N1+parity frames with parity/framing checks.
// Optional define UART_RX_MAJORITY_VOTE_EN: each bit is a 3-sample majority (ticks 7..9).

module uart_receiver #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_BUSY
);

  function automatic logic [13:0] calc_div(input int baud);
    return 14'((CLK_FREQ_HZ + 8 * baud) / (16 * baud));
  endfunction

  localparam logic [13:0] DIV_300    = calc_div(300);
  localparam logic [13:0] DIV_1200   = calc_div(1200);
  localparam logic [13:0] DIV_4800   = calc_div(4800);
  localparam logic [13:0] DIV_9600   = calc_div(9600);
  localparam logic [13:0] DIV_19200  = calc_div(19200);
  localparam logic [13:0] DIV_38400  = calc_div(38400);
  localparam logic [13:0] DIV_57600  = calc_div(57600);
  localparam logic [13:0] DIV_115200 = calc_div(115200);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] START_POINT = 4'd8;
`else
  localparam logic [3:0] START_POINT = 4'd7;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_next;
  logic        rxd_meta, rxd_s;
  logic [13:0] baud_div, divisor, tick_cnt;
  logic [3:0]  sample_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        perr_q;
  logic        armed;
  logic        tick, start_req, start_mid, bit_mid, bit_val, frame_done;

  always_comb begin
    baud_div = DIV_115200;
    case (baud_select)
      3'b000:  baud_div = DIV_300;
      3'b001:  baud_div = DIV_1200;
      3'b010:  baud_div = DIV_4800;
      3'b011:  baud_div = DIV_9600;
      3'b100:  baud_div = DIV_19200;
      3'b101:  baud_div = DIV_38400;
      3'b110:  baud_div = DIV_57600;
      default: baud_div = DIV_115200;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_s    <= rxd_meta;
    end
  end

  assign tick      = (state != IDLE) && (tick_cnt == 14'd0);
  assign start_req = Rx_EN && !rxd_s && armed;
  assign start_mid = tick && (state == START) && (sample_cnt == START_POINT);
  assign bit_mid   = tick && (sample_cnt == 4'd15);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      vote_hist <= 2'b11;
    else if (tick)
      vote_hist <= {vote_hist[0], rxd_s};
  end

  assign bit_val = (vote_hist[1] & vote_hist[0]) | (vote_hist[1] & rxd_s) |
                   (vote_hist[0] & rxd_s);
`else
  assign bit_val = rxd_s;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Dropping Rx_EN outranks any tick that lands in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_req) state_next = START;
      START:   if (!Rx_EN) state_next = IDLE;
               else if (start_mid) state_next = bit_val ? IDLE : DATA;
      DATA:    if (!Rx_EN) state_next = IDLE;
               else if (bit_mid && (bit_cnt == 3'd7)) state_next = PARITY;
      PARITY:  if (!Rx_EN) state_next = IDLE;
               else if (bit_mid) state_next = STOP;
      STOP:    if (!Rx_EN || bit_mid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Rx_BUSY    = (state != IDLE);
    frame_done = (state == STOP) && Rx_EN && bit_mid;
  end

  // Divisor is frozen at start detection so baud changes only hit the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divisor  <= 14'd0;
      tick_cnt <= 14'd0;
    end else if (state == IDLE) begin
      if (start_req) begin
        divisor  <= baud_div;
        tick_cnt <= baud_div - 14'd1;
      end
    end else if (tick) begin
      tick_cnt <= divisor - 14'd1;
    end else begin
      tick_cnt <= tick_cnt - 14'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt <= 4'd0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      perr_q     <= 1'b0;
    end else if (state == IDLE) begin
      sample_cnt <= 4'd0;
      bit_cnt    <= 3'd0;
    end else if (tick) begin
      sample_cnt <= start_mid ? 4'd0 : sample_cnt + 4'd1;
      if ((state == DATA) && bit_mid) begin
        shift   <= {bit_val, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if ((state == PARITY) && bit_mid)
        perr_q <= (^shift) ^ bit_val ^ PARITY_ODD;
    end
  end

  // A frame ending on a low line (break) must see the line high before re-arming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      armed <= 1'b1;
    else if (rxd_s)
      armed <= 1'b1;
    else if ((state != IDLE) && (state_next == IDLE))
      armed <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID <= frame_done;
      if (frame_done) begin
        Rx_DATA   <= shift;
        Rx_PERROR <= perr_q;
        Rx_FERROR <= ~bit_val;
      end
    end
  end

endmodule
